idwt_pipe: RTL and testbench
============================

# idwt_pipe

Pipelined 64-point inverse Discrete Walsh Transform. Accepts one full vector of 64 signed 22-bit Walsh coefficients per cycle, in the exact packing and ordering produced by the forward DWT block, and returns the 64 reconstructed signed 16-bit samples. It sits on the receive/reconstruction side of the DWT datapath; DWT feeding idwt_pipe forms a bit-exact identity loop.

## Interface
Parameters:
- N, 64: transform length; fixed, power of two.
- CW, 22: coefficient width, signed.
- DW, 16: sample width, signed.

Ports:
- iCLK  in  1  sole clock, rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iVALID  in  1  iDATA holds a valid coefficient vector this cycle.
- iDATA  in  CW*N  coefficients; element k at iDATA[CW*(N-k)-1 -: CW], so element 0 is in the MSBs. Natural Hadamard order.
- oVALID  out  1  oDATA holds a valid sample vector.
- oDATA  out  DW*N  samples; element n at oDATA[DW*(N-n)-1 -: DW].
- oRNDERR  out  1  qualified by oVALID. At least one pre-scale sum was not divisible by N.
- oSATERR  out  1  qualified by oVALID. At least one sample was clipped.

## Operation
- No back-pressure. Every cycle with iVALID=1 is accepted. Throughput is one vector per cycle.
- Datapath: 6 butterfly stages (log2 N), then one scale/saturate stage.
- Butterfly stage s, for s=0..5, uses stride h=2^s. For each pair (i, i+h) where bit s of i is 0: a'=a+b, b'=a-b.
- Width growth: one bit per stage, sign-extended. Stage s output width is CW+s+1. Final sum width is 28 bits. No wrap can occur.
- Scale: y = sum >>> 6 (arithmetic shift, floor toward -inf). Rounding error is flagged if sum[5:0] != 0.
- Saturate y to [-32768, 32767]. Saturation is flagged if y is outside that range.
- oRNDERR and oSATERR are the OR over all 64 lanes of that vector. They are per-vector, not sticky.
- iVALID travels down a valid shift register alongside the data.
- Data registers are gated by valid (hold when invalid) to save power. oDATA is only meaningful when oVALID=1.

## Timing
- Latency is exactly 7 cycles. A vector sampled with iVALID=1 at edge t appears with oVALID=1 after edge t+7.
- Back-to-back inputs produce back-to-back outputs in order. Gaps in iVALID are preserved cycle-for-cycle.
- Reset (iRST_N=0, async): all valid-pipe bits=0, oVALID=0, oDATA=0, oRNDERR=0, oSATERR=0, and all stage registers=0.
- Reset mid-operation: all in-flight vectors are discarded. Nothing emerges after release unless new iVALID arrives. The first post-reset output comes 7 cycles after the first accepted vector.
- iVALID=1 during reset is ignored.
- Reset deassertion is assumed synchronised upstream; the block is async-assert only.

## Structure
- Package dwt_pkg: N, LOG2N=6, CW, DW, SUMW=CW+LOG2N, and element index/slice helper functions. This package is shared with the forward DWT block.
- Sub-module idwt_stage, parameters STRIDE and IW:
  - one registered butterfly layer with valid in/out and async reset;
  - instantiated 6 times through a generate loop.
- Scale/saturate/flag logic lives in the top level, idwt_pipe.

## Test plan
- Impulse: X[0]=64, others 0 -> all 64 samples = 1, oRNDERR=0, oSATERR=0. oVALID rises exactly 7 cycles after iVALID.
- Ramp round-trip: X[0]=2016, X[1]=-32, X[2]=-64, X[4]=-128, X[8]=-256, X[16]=-512, X[32]=-1024, others 0 -> y[n]=n for n=0..63, flags 0.
- Negative and rounding:
  - X[0]=-64 -> all samples -1.
  - X[0]=1 -> all samples 0, oRNDERR=1.
  - X[0]=-1 -> all samples -1, oRNDERR=1.
- Saturation: X[0]=X[1]=2000000, others 0 -> even n = 32767, odd n = 0, oSATERR=1. X[0]=X[1]=-2000000 -> even n = -32768, oSATERR=1.
- Streaming: 20 consecutive random vectors with random iVALID gaps, checked against a reference model -> outputs in order, same gap pattern, exactly 7-cycle offset.
- Reset mid-stream: assert iRST_N=0 asynchronously between edges with 3 vectors in flight -> oVALID=0 and oDATA=0 immediately. No stale vector emerges after release.

Source files
------------

// File: rtl/dwt_pkg.sv
// rtl/dwt_pkg.sv - shared constants and lane slicing helpers for the DWT/IDWT datapath
package dwt_pkg;

  localparam int N     = 64;
  localparam int LOG2N = 6;
  localparam int CW    = 22;
  localparam int DW    = 16;
  localparam int SUMW  = CW + LOG2N;

  // Element 0 sits in the MSBs, so lane k of a w-bit-per-lane bus starts here
  function automatic int elem_lsb(input int w, input int k);
    return w * (N - 1 - k);
  endfunction

  function automatic int elem_msb(input int w, input int k);
    return w * (N - k) - 1;
  endfunction

  // Offset of butterfly stage s output inside the flattened inter-stage bus
  function automatic int stage_off(input int s);
    return N * (s * CW + (s * (s + 1)) / 2);
  endfunction

endpackage

// File: rtl/idwt_stage.sv
// rtl/idwt_stage.sv - one registered Walsh butterfly layer with valid pass-through
module idwt_stage
  import dwt_pkg::*;
#(
  parameter int STRIDE = 1,
  parameter int IW     = 22
) (
  input  logic                  user_clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  input  logic [N*IW-1:0]       s_tdata,
  output logic                  m_tvalid,
  output logic [N*(IW+1)-1:0]   m_tdata
);

  localparam int OW = IW + 1;

  logic [N*OW-1:0] bfly;

  // Pair (i, i+STRIDE) with STRIDE bit clear in i: upper lane takes the sum, lower the difference
  for (genvar i = 0; i < N; i++) begin : g_lane
    if ((i & STRIDE) == 0) begin : g_sum
      logic signed [IW-1:0] a;
      logic signed [IW-1:0] b;
      assign a = s_tdata[elem_lsb(IW, i) +: IW];
      assign b = s_tdata[elem_lsb(IW, i + STRIDE) +: IW];
      assign bfly[elem_lsb(OW, i) +: OW] = {a[IW-1], a} + {b[IW-1], b};
    end else begin : g_diff
      logic signed [IW-1:0] a;
      logic signed [IW-1:0] b;
      assign a = s_tdata[elem_lsb(IW, i - STRIDE) +: IW];
      assign b = s_tdata[elem_lsb(IW, i) +: IW];
      assign bfly[elem_lsb(OW, i) +: OW] = {a[IW-1], a} - {b[IW-1], b};
    end
  end

  // Register the layer; data only loads on valid cycles to avoid needless toggling
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else begin
      m_tvalid <= s_tvalid;
      if (s_tvalid) begin
        m_tdata <= bfly;
      end
    end
  end

endmodule

// File: rtl/idwt_pipe.sv
// rtl/idwt_pipe.sv - pipelined 64-point inverse Walsh transform with scale and saturate
module idwt_pipe
  import dwt_pkg::*;
#(
  parameter int N  = dwt_pkg::N,
  parameter int CW = dwt_pkg::CW,
  parameter int DW = dwt_pkg::DW
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iVALID,
  input  logic [CW*N-1:0] iDATA,
  output logic            oVALID,
  output logic [DW*N-1:0] oDATA,
  output logic            oRNDERR,
  output logic            oSATERR
);

  localparam int YW = SUMW - LOG2N;
  localparam logic signed [YW-1:0] Y_MAX = YW'((2 ** (DW - 1)) - 1);
  localparam logic signed [YW-1:0] Y_MIN = -YW'(2 ** (DW - 1));

  // Every stage output lives in one flat bus, each slice one bit wider than the last
  logic [stage_off(LOG2N)-1:0] stage_bus;
  logic [LOG2N:0]              valid_pipe;

  assign valid_pipe[0] = iVALID;

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int IW = CW + s;
    if (s == 0) begin : g_first
      idwt_stage #(.STRIDE(1 << s), .IW(IW)) u_stage (
        .user_clk (iCLK),
        .rst_n    (iRST_N),
        .s_tvalid (valid_pipe[s]),
        .s_tdata  (iDATA),
        .m_tvalid (valid_pipe[s+1]),
        .m_tdata  (stage_bus[stage_off(s) +: N*(IW+1)])
      );
    end else begin : g_next
      idwt_stage #(.STRIDE(1 << s), .IW(IW)) u_stage (
        .user_clk (iCLK),
        .rst_n    (iRST_N),
        .s_tvalid (valid_pipe[s]),
        .s_tdata  (stage_bus[stage_off(s-1) +: N*IW]),
        .m_tvalid (valid_pipe[s+1]),
        .m_tdata  (stage_bus[stage_off(s) +: N*(IW+1)])
      );
    end
  end

  logic [N*SUMW-1:0] sum_bus;
  logic [DW*N-1:0]   samples;
  logic              rnd_any;
  logic              sat_any;

  assign sum_bus = stage_bus[stage_off(LOG2N-1) +: N*SUMW];

  // Divide by N with floor (drop low bits), flag lost remainder, clip to the sample range
  always_comb begin
    logic signed [SUMW-1:0] sum;
    logic signed [YW-1:0]   y;
    samples = '0;
    rnd_any = 1'b0;
    sat_any = 1'b0;
    sum     = '0;
    y       = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum_bus[elem_lsb(SUMW, k) +: SUMW];
      y   = sum[SUMW-1:LOG2N];
      if (sum[LOG2N-1:0] != '0) begin
        rnd_any = 1'b1;
      end
      if (y > Y_MAX) begin
        samples[DW*(N-k)-1 -: DW] = {1'b0, {(DW-1){1'b1}}};
        sat_any = 1'b1;
      end else if (y < Y_MIN) begin
        samples[DW*(N-k)-1 -: DW] = {1'b1, {(DW-1){1'b0}}};
        sat_any = 1'b1;
      end else begin
        samples[DW*(N-k)-1 -: DW] = y[DW-1:0];
      end
    end
  end

  // Output register: last valid bit plus gated sample vector and per-vector flags
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVALID  <= 1'b0;
      oDATA   <= '0;
      oRNDERR <= 1'b0;
      oSATERR <= 1'b0;
    end else begin
      oVALID <= valid_pipe[LOG2N];
      if (valid_pipe[LOG2N]) begin
        oDATA   <= samples;
        oRNDERR <= rnd_any;
        oSATERR <= sat_any;
      end
    end
  end

endmodule

// File: tb/tb_idwt_pipe.sv
// tb/tb_idwt_pipe.sv - scoreboard bench for idwt_pipe
module tb_idwt_pipe;
  import dwt_pkg::*;

  logic            iCLK;
  logic            iRST_N;
  logic            iVALID;
  logic [CW*N-1:0] iDATA;
  logic            oVALID;
  logic [DW*N-1:0] oDATA;
  logic            oRNDERR;
  logic            oSATERR;

  idwt_pipe #(.N(N), .CW(CW), .DW(DW)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iVALID  (iVALID),
    .iDATA   (iDATA),
    .oVALID  (oVALID),
    .oDATA   (oDATA),
    .oRNDERR (oRNDERR),
    .oSATERR (oSATERR)
  );

  typedef struct {
    logic [DW*N-1:0] data;
    logic            rnd;
    logic            sat;
    int              cyc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   xv[N];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  function automatic logic [CW*N-1:0] pack_x();
    logic [CW*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[CW*(N-k)-1 -: CW] = CW'(xv[k]);
    return v;
  endfunction

  function automatic logic [DW*N-1:0] rep(input int val);
    logic [DW*N-1:0] v;
    for (int n = 0; n < N; n++) v[DW*(N-n)-1 -: DW] = DW'(val);
    return v;
  endfunction

  // Direct Walsh sum per sample (no butterflies), then floor-divide and clip
  task automatic model(output logic [DW*N-1:0] d, output logic rnd, output logic sat);
    longint s;
    longint y;
    d = '0; rnd = 1'b0; sat = 1'b0;
    for (int n = 0; n < N; n++) begin
      s = 0;
      for (int k = 0; k < N; k++) begin
        if (($countones(n & k) % 2) == 1) s = s - xv[k];
        else s = s + xv[k];
      end
      y = s >>> 6;
      if ((s & 64'sd63) != 0) rnd = 1'b1;
      if (y > 32767) begin y = 32767; sat = 1'b1; end
      if (y < -32768) begin y = -32768; sat = 1'b1; end
      d[DW*(N-n)-1 -: DW] = DW'(y);
    end
  endtask

  task automatic clear_x();
    for (int k = 0; k < N; k++) xv[k] = 0;
  endtask

  task automatic send(input logic [DW*N-1:0] d, input logic rnd, input logic sat);
    exp_t e;
    iDATA  = pack_x();
    iVALID = 1'b1;
    e.data = d; e.rnd = rnd; e.sat = sat; e.cyc = cyc + 7;
    sb.push_back(e);
    @(posedge iCLK); #1;
    iVALID = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic cmp_vec(input string name, input logic [DW*N-1:0] got, input logic [DW*N-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      for (int n = 0; n < N; n++) begin
        if (got[DW*(N-n)-1 -: DW] !== want[DW*(N-n)-1 -: DW]) begin
          $display("FAIL %s lane=%0d got=%0d want=%0d", name, n,
                   $signed(got[DW*(N-n)-1 -: DW]), $signed(want[DW*(N-n)-1 -: DW]));
          break;
        end
      end
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Monitor: every output must match the oldest expectation on its exact cycle
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oVALID) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          failures += 0;
          if (e.cyc != cyc) begin
            failures++;
            $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
          end
          cmp_vec("odata", oDATA, e.data);
          cmp_bit("ornderr", oRNDERR, e.rnd);
          cmp_bit("osaterr", oSATERR, e.sat);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_output got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic [DW*N-1:0] d;
    logic            r;
    logic            s;
    int              wait_cnt;

    iRST_N = 1'b0;
    iVALID = 1'b0;
    iDATA  = '0;
    clear_x();
    idle(2);
    cmp_bit("reset_ovalid", oVALID, 1'b0);
    cmp_vec("reset_odata", oDATA, '0);
    cmp_bit("reset_rnd", oRNDERR, 1'b0);
    cmp_bit("reset_sat", oSATERR, 1'b0);

    // Valid asserted while held in reset must be dropped
    xv[0] = 64;
    iDATA  = pack_x();
    iVALID = 1'b1;
    idle(3);
    iVALID = 1'b0;
    iRST_N = 1'b1;
    idle(10);

    // Impulse
    clear_x(); xv[0] = 64;
    send(rep(1), 1'b0, 1'b0);
    idle(9);

    // Ramp round-trip: y[n] = n
    clear_x();
    xv[0] = 2016; xv[1] = -32; xv[2] = -64; xv[4] = -128;
    xv[8] = -256; xv[16] = -512; xv[32] = -1024;
    for (int n = 0; n < N; n++) d[DW*(N-n)-1 -: DW] = DW'(n);
    send(d, 1'b0, 1'b0);

    // Negative and rounding, back to back
    clear_x(); xv[0] = -64; send(rep(-1), 1'b0, 1'b0);
    clear_x(); xv[0] = 1;   send(rep(0),  1'b1, 1'b0);
    clear_x(); xv[0] = -1;  send(rep(-1), 1'b1, 1'b0);

    // Saturation both directions
    clear_x(); xv[0] = 2000000; xv[1] = 2000000;
    for (int n = 0; n < N; n++) d[DW*(N-n)-1 -: DW] = (n % 2 == 0) ? 16'h7fff : 16'h0000;
    send(d, 1'b0, 1'b1);
    clear_x(); xv[0] = -2000000; xv[1] = -2000000;
    for (int n = 0; n < N; n++) d[DW*(N-n)-1 -: DW] = (n % 2 == 0) ? 16'h8000 : 16'h0000;
    send(d, 1'b0, 1'b1);
    idle(10);

    // Streaming with random gaps against the direct-sum model
    for (int v = 0; v < 20; v++) begin
      for (int k = 0; k < N; k++) begin
        if (v % 2 == 0) xv[k] = int'($urandom_range(0, 8191)) - 4096;
        else            xv[k] = int'($urandom_range(0, 4194303)) - 2097152;
      end
      model(d, r, s);
      send(d, r, s);
      idle(int'($urandom_range(0, 2)));
    end
    idle(10);

    // Reset with three vectors in flight
    for (int v = 0; v < 3; v++) begin
      clear_x(); xv[v] = 64 * (v + 1);
      model(d, r, s);
      send(d, r, s);
    end
    idle(2);
    #2;
    iRST_N = 1'b0;
    #1;
    cmp_bit("midreset_ovalid", oVALID, 1'b0);
    cmp_vec("midreset_odata", oDATA, '0);
    sb.delete();
    idle(2);
    iRST_N = 1'b1;
    idle(12);

    // First vector after reset keeps the full latency
    clear_x(); xv[0] = 128;
    send(rep(2), 1'b0, 1'b0);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 30) begin
      idle(1);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
